// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand sequencer and the ALU mux it feeds.
//   state_e : FSM state encodings, also shown on the state LEDs
//   OP_*    : opcode values as decoded by the ALU mux (3-bit default opcode width)
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

endpackage

// File: rtl/rise_edge_det.sv
// One-bit rising-edge detector.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   d     : level input
//   rise  : combinational pulse, high when d is 1 now and was 0 on the previous edge
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q, d_d;

  assign d_d  = d;
  assign rise = d & ~d_q;

  // Resetting to 1 means a level already high at reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q <= 1'b1;
    end else begin
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Steps a shared switch bus into ALU operand A, operand B and the opcode on successive
// rising edges of the load button, waits one cycle for the ALU, captures its result and
// flags, then shows them until the next load press returns to operand A.
//   clk, rst_n         : clock, synchronous active-low reset
//   clr                : synchronous clear of state and all registers
//   load               : debounced button level
//   data_in [N-1:0]    : switch bus (opcode in [OPW-1:0])
//   A, B [N-1:0]       : registered operands to the ALU
//   op [OPW-1:0]       : registered opcode to the ALU mux
//   alu_y, alu_cout    : combinational ALU result and carry/borrow
//   result, flag_z/c   : registered ALU result and flags
//   res_valid          : high while result and flags are held valid
//   state [2:0]        : FSM state code for the LEDs
// N must be at least OPW.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           load,
  input  logic [N-1:0]   data_in,
  output logic [N-1:0]   A,
  output logic [N-1:0]   B,
  output logic [OPW-1:0] op,
  input  logic [N-1:0]   alu_y,
  input  logic           alu_cout,
  output logic [N-1:0]   result,
  output logic           flag_z,
  output logic           flag_c,
  output logic           res_valid,
  output logic [2:0]     state
);

  logic load_edge;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [OPW-1:0] op_q, op_d;
  logic [N-1:0]   result_q, result_d;
  logic           flag_z_q, flag_z_d;
  logic           flag_c_q, flag_c_d;
  logic           res_valid_q, res_valid_d;

  rise_edge_det u_load_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (load),
    .rise  (load_edge)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    result_d    = result_q;
    flag_z_d    = flag_z_q;
    flag_c_d    = flag_c_q;
    res_valid_d = res_valid_q;

    if (clr) begin
      // Clear wins over any load edge in the same cycle, in every state.
      state_d     = S_A;
      a_d         = '0;
      b_d         = '0;
      op_d        = '0;
      result_d    = '0;
      flag_z_d    = 1'b0;
      flag_c_d    = 1'b0;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (load_edge) begin
            a_d     = data_in;
            state_d = S_B;
          end
        end
        S_B: begin
          if (load_edge) begin
            b_d     = data_in;
            state_d = S_OP;
          end
        end
        S_OP: begin
          if (load_edge) begin
            op_d    = data_in[OPW-1:0];
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          // A, B and op are stable here, so alu_y has settled by the end of this cycle.
          result_d    = alu_y;
          flag_z_d    = (alu_y == '0);
          flag_c_d    = alu_cout;
          res_valid_d = 1'b1;
          state_d     = S_SHOW;
        end
        S_SHOW: begin
          if (load_edge) begin
            res_valid_d = 1'b0;
            state_d     = S_A;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      result_q    <= result_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign op        = op_q;
  assign result    = result_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign res_valid = res_valid_q;
  assign state     = state_q;

endmodule
